pipeline_hazard_ctrl: RTL and testbench

//   Sequences the ID/EX pipeline register and the front-end stages: detects RAW load-use hazards,

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 18 +
 rtl/pipeline_hazard_ctrl_if.sv | 35 +++
 rtl/pipeline_hazard_ctrl_hazard_cmp.sv | 14 +
 rtl/pipeline_hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the ID/EX pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W = 4;

  localparam logic [3:0] CMD_NOP = 4'h0;
  localparam logic [3:0] CMD_ADD = 4'h1;
  localparam logic [3:0] CMD_LDR = 4'h8;
  localparam logic [3:0] CMD_MUL = 4'hA;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LD_STALL = 2'd1,
    ST_MUL_BUSY = 2'd2,
    ST_BR_FLUSH = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode/EXE/MEM status in, pipeline stall/flush/hold controls out.
interface pipeline_hazard_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic             id_valid;
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_two_src;
  logic [3:0]       id_exe_cmd;
  logic [REG_W-1:0] exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_r_en;
  logic [REG_W-1:0] mem_dest;
  logic             mem_wb_en;
  logic             br_taken;

  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_exe_flush;
  logic             exe_hold;
  logic [15:0]      stall_cnt;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src, id_exe_cmd,
           exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en, br_taken,
    input  pc_stall, if_id_stall, if_id_flush, id_exe_flush, exe_hold, stall_cnt
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, id_exe_cmd,
           exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en, br_taken,
    output pc_stall, if_id_stall, if_id_flush, id_exe_flush, exe_hold, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_cmp.sv
// RAW compare of the Decode sources against one downstream destination.
module hazard_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic             valid_i,
  input  logic [REG_W-1:0] src1_i,
  input  logic [REG_W-1:0] src2_i,
  input  logic             two_src_i,
  input  logic [REG_W-1:0] dest_i,
  input  logic             en_i,
  output logic             raw_o
);
  assign raw_o = en_i & valid_i & ((src1_i == dest_i) | (two_src_i & (src2_i == dest_i)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / multi-cycle / branch-flush sequencer for PC, IF/ID and ID/EX.
// Define HAZ_FWD_EN when forwarding exists: only load-use then stalls.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT   = 3,
  parameter int unsigned FLUSH_LEN = 1,
  parameter logic [3:0]  MUL_CMD   = CMD_MUL
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int unsigned BW = $clog2(MUL_LAT + 1);
  localparam int unsigned FW = $clog2(FLUSH_LEN + 1);

  ctrl_state_t   state_q, state_d;
  logic [BW-1:0] busy_cnt_q, busy_cnt_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic [15:0]   stall_cnt_q, stall_cnt_d;

  logic load_use, raw_nofwd;
  logic pc_stall, if_id_stall, if_id_flush, id_exe_flush, exe_hold;

  hazard_cmp u_cmp_load (
    .valid_i(bus.id_valid), .src1_i(bus.id_src1), .src2_i(bus.id_src2),
    .two_src_i(bus.id_two_src), .dest_i(bus.exe_dest), .en_i(bus.exe_mem_r_en),
    .raw_o(load_use)
  );

`ifdef HAZ_FWD_EN
  assign raw_nofwd = 1'b0;
`else
  logic raw_exe, raw_mem;

  hazard_cmp u_cmp_exe (
    .valid_i(bus.id_valid), .src1_i(bus.id_src1), .src2_i(bus.id_src2),
    .two_src_i(bus.id_two_src), .dest_i(bus.exe_dest), .en_i(bus.exe_wb_en),
    .raw_o(raw_exe)
  );

  hazard_cmp u_cmp_mem (
    .valid_i(bus.id_valid), .src1_i(bus.id_src1), .src2_i(bus.id_src2),
    .two_src_i(bus.id_two_src), .dest_i(bus.mem_dest), .en_i(bus.mem_wb_en),
    .raw_o(raw_mem)
  );

  assign raw_nofwd = raw_exe | raw_mem;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      busy_cnt_q  <= '0;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_cnt_q  <= busy_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    busy_cnt_d   = busy_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_exe_flush = 1'b0;
    exe_hold     = 1'b0;

    if (state_q == ST_MUL_BUSY) begin
      // EXE is the multiplier here, so a br_taken seen now is spurious and ignored.
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      exe_hold    = 1'b1;
      busy_cnt_d  = busy_cnt_q - BW'(1);
      if (busy_cnt_q == BW'(1)) state_d = ST_RUN;
    end else if (bus.br_taken) begin
      if_id_flush  = 1'b1;
      id_exe_flush = 1'b1;
      if (FLUSH_LEN > 1) begin
        state_d     = ST_BR_FLUSH;
        flush_cnt_d = FW'(FLUSH_LEN - 1);
      end else begin
        state_d = ST_RUN;
      end
    end else if (state_q == ST_BR_FLUSH) begin
      if_id_flush  = 1'b1;
      id_exe_flush = 1'b1;
      flush_cnt_d  = flush_cnt_q - FW'(1);
      if (flush_cnt_q == FW'(1)) state_d = ST_RUN;
    end else if (state_q == ST_LD_STALL) begin
      state_d = ST_RUN;
    end else if (load_use) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_exe_flush = 1'b1;
      state_d      = ST_LD_STALL;
    end else if (raw_nofwd) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_exe_flush = 1'b1;
    end else if (bus.id_valid && (bus.id_exe_cmd == MUL_CMD)) begin
      state_d    = ST_MUL_BUSY;
      busy_cnt_d = BW'(MUL_LAT - 1);
    end

    stall_cnt_d = (pc_stall && (stall_cnt_q != '1)) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end

  assign bus.pc_stall     = pc_stall;
  assign bus.if_id_stall  = if_id_stall;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_exe_flush = id_exe_flush;
  assign bus.exe_hold     = exe_hold;
  assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Random + directed bench for pipeline_hazard_ctrl against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int unsigned MUL_LAT   = 3;
  localparam int unsigned FLUSH_LEN = 2;

  typedef struct {
    bit v; logic [3:0] s1; logic [3:0] s2; bit two; logic [3:0] cmd;
    logic [3:0] ed; bit ewb; bit eld; logic [3:0] md; bit mwb; bit br;
  } stim_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(
    .MUL_LAT  (MUL_LAT),
    .FLUSH_LEN(FLUSH_LEN),
    .MUL_CMD  (CMD_MUL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: remaining hold/flush cycles, pending load bubble, stall total.
  int busy_left, flush_left, cnt;
  bit ld_pending;
  int n_busy, n_flush, n_cnt;
  bit n_ld;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{v:0, s1:0, s2:0, two:0, cmd:CMD_NOP, ed:0, ewb:0, eld:0, md:0, mwb:0, br:0};
    return s;
  endfunction

  function automatic bit reads(input stim_t s, input logic [3:0] r);
    return s.v && ((s.s1 == r) || (s.two && (s.s2 == r)));
  endfunction

  task automatic drive(input stim_t s);
    bus.id_valid = s.v;   bus.id_src1 = s.s1;   bus.id_src2 = s.s2;
    bus.id_two_src = s.two; bus.id_exe_cmd = s.cmd;
    bus.exe_dest = s.ed;  bus.exe_wb_en = s.ewb; bus.exe_mem_r_en = s.eld;
    bus.mem_dest = s.md;  bus.mem_wb_en = s.mwb; bus.br_taken = s.br;
  endtask

  task automatic model_reset();
    busy_left = 0; flush_left = 0; ld_pending = 0; cnt = 0;
  endtask

  // Expected {pc_stall, if_id_stall, if_id_flush, id_exe_flush, exe_hold}.
  task automatic model_eval(input stim_t s, output logic [4:0] e);
    bit lu, rawx;
    lu   = s.eld && reads(s, s.ed);
    rawx = 0;
`ifndef HAZ_FWD_EN
    rawx = (s.ewb && reads(s, s.ed)) || (s.mwb && reads(s, s.md));
`endif
    n_busy = busy_left; n_flush = flush_left; n_ld = 0; e = '0;
    if (busy_left > 0)       begin e = 5'b11001; n_busy = busy_left - 1; end
    else if (s.br)           begin e = 5'b00110; n_flush = FLUSH_LEN - 1; end
    else if (flush_left > 0) begin e = 5'b00110; n_flush = flush_left - 1; end
    else if (ld_pending)     e = '0;
    else if (lu)             begin e = 5'b11010; n_ld = 1; end
    else if (rawx)           e = 5'b11010;
    else if (s.v && s.cmd == CMD_MUL) n_busy = MUL_LAT - 1;
    n_cnt = e[4] ? ((cnt >= 65535) ? 65535 : cnt + 1) : cnt;
  endtask

  task automatic apply(input stim_t s);
    logic [4:0] e;
    @(negedge clk);
    drive(s);
    #1;
    model_eval(s, e);
    check_eq("ctrl", {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_exe_flush, bus.exe_hold}, e);
    check_eq("stall_cnt", bus.stall_cnt, cnt);
    @(posedge clk);
    busy_left = n_busy; flush_left = n_flush; ld_pending = n_ld; cnt = n_cnt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(idle());
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  stim_t s;

  initial begin
    drive(idle());
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_ctrl", {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_exe_flush, bus.exe_hold}, 0);
    check_eq("reset_cnt", bus.stall_cnt, 0);
    rst = 1'b0;

    // 1: LDR r3 in EXE, ADD r3 in ID.
    s = idle(); s.v = 1; s.s1 = 4'd3; s.s2 = 4'd7; s.two = 1; s.cmd = CMD_ADD;
    s.ed = 4'd3; s.ewb = 1; s.eld = 1;
    apply(s);
    s.ed = 4'd9; s.eld = 0; s.ewb = 0;
    apply(s);
    #1 check_eq("t1_cnt", bus.stall_cnt, 1);

    // 2: multi-cycle issue, then a stray br_taken while busy.
    s = idle(); s.v = 1; s.cmd = CMD_MUL; s.s1 = 4'd1;
    apply(s);
    s = idle(); s.br = 1;
    apply(s);
    apply(idle());
    apply(idle());
    #1 check_eq("t2_cnt", bus.stall_cnt, 3);

    // 3: branch wins over load-use, FLUSH_LEN=2.
    do_reset();
    s = idle(); s.v = 1; s.s1 = 4'd4; s.ed = 4'd4; s.eld = 1; s.br = 1;
    apply(s);
    s.br = 0;
    apply(s);
    apply(idle());
    #1 check_eq("t3_cnt", bus.stall_cnt, 0);

    // 4: asynchronous reset in the middle of MUL_BUSY.
    s = idle(); s.v = 1; s.cmd = CMD_MUL;
    apply(s);
    apply(idle());
    @(negedge clk);
    drive(idle());
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async_ctrl", {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_exe_flush, bus.exe_hold}, 0);
    check_eq("rst_async_cnt", bus.stall_cnt, 0);
    rst = 1'b0;
    model_reset();
    apply(idle());

    // 5: ALU result r5 in MEM read by Decode.
    s = idle(); s.v = 1; s.s1 = 4'd5; s.md = 4'd5; s.mwb = 1; s.ed = 4'd2;
    apply(s);
`ifdef HAZ_FWD_EN
    #1 check_eq("t5_cnt", bus.stall_cnt, 0);
`else
    #1 check_eq("t5_cnt", bus.stall_cnt, 1);
`endif

    // Register 0 hazards are not exempt.
    do_reset();
    s = idle(); s.v = 1; s.s2 = 4'd0; s.s1 = 4'd6; s.two = 1; s.ed = 4'd0; s.eld = 1;
    apply(s);
    #1 check_eq("r0_cnt", bus.stall_cnt, 1);

    // Randomized traffic over a small register window to provoke hits.
    for (int i = 0; i < 3000; i++) begin
      s.v = ($urandom_range(0, 9) != 0); s.two = $urandom_range(0, 1);
      s.s1 = 4'($urandom_range(0, 3)); s.s2 = 4'($urandom_range(0, 3));
      s.cmd = ($urandom_range(0, 5) == 0) ? CMD_MUL : 4'($urandom_range(0, 9));
      s.ed = 4'($urandom_range(0, 3)); s.ewb = $urandom_range(0, 1);
      s.eld = ($urandom_range(0, 3) == 0);
      s.md = 4'($urandom_range(0, 3)); s.mwb = $urandom_range(0, 1);
      s.br = ($urandom_range(0, 9) == 0);
      apply(s);
    end

`ifndef HAZ_FWD_EN
    // 6: saturation of the stall counter with back-to-back RAW stalls.
    do_reset();
    s = idle(); s.v = 1; s.s1 = 4'd2; s.ed = 4'd2; s.ewb = 1;
    for (int i = 0; i < 65600; i++) apply(s);
    #1 check_eq("t6_sat", bus.stall_cnt, 16'hFFFF);
    apply(idle());
    #1 check_eq("t6_hold", bus.stall_cnt, 16'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
